// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Constants, FSM state type and store lane helpers for the memory stage.
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Byte enables for a store; unknown sizes write the whole word.
    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_SB:   return 4'b0001 << off;
            F3_SH:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Store data is replicated across lanes so the strobes alone pick the bytes.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] b);
        case (f3)
            F3_SB:   return {4{b[7:0]}};
            F3_SH:   return {2{b[15:0]}};
            default: return b;
        endcase
    endfunction

endpackage

// File: rtl/pipe_bus_pkg.sv
// -----------------------------------------------------------------------------
// pipe_bus_pkg
// Pipeline interface header: inter-stage bus structures shared by the
// execute, memory and writeback stages.
//   ex_mem_bus_t : execute -> memory stage payload
//   mem_wb_bus_t : memory  -> writeback stage payload
// -----------------------------------------------------------------------------
package pipe_bus_pkg;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] alu_result;   // effective address or ALU value
        logic [31:0] b_val;        // store data
        logic [6:0]  opcode;
        logic [4:0]  rd;
    } ex_mem_bus_t;

    typedef struct packed {
        logic [31:0] wb_value;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [31:0] instruction;
    } mem_wb_bus_t;

endpackage

// File: rtl/mem_load_align.sv
// -----------------------------------------------------------------------------
// mem_load_align
// Combinational load aligner: selects the addressed byte/halfword from the
// read word and sign- or zero-extends it.
//   rdata_i  : 32-bit word returned by the data memory
//   funct3_i : load size/sign selector
//   off_i    : byte offset within the word
//   value_o  : extended load value
// -----------------------------------------------------------------------------
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    output logic [31:0] value_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_LB:   value_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  value_o = {24'd0, byte_sel};
            F3_LH:   value_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  value_o = {16'd0, half_sel};
            default: value_o = rdata_i;   // LW and reserved encodings
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access pipeline stage. Non-memory ops pass to MEM/WB in one cycle;
// loads/stores go out on a valid/ready request channel and complete on a
// separate response pulse, with mem_stall holding upstream meanwhile.
//
// Parameter:
//   STORE_WAIT_RSP : 1 = store completes on its response,
//                    0 = store completes on the request handshake
// Optional feature macro:
//   MEM_MISALIGN_TRAP_EN : flag misaligned half/word accesses instead of
//                          issuing them (misaligned tied 0 when undefined)
// Ports:
//   clock, reset                 : clock, async active-high reset
//   ex_mem_bus_in, ex_mem_valid  : incoming instruction from execute
//   mem_stall                    : upstream must hold its outputs
//   dmem_req_*                   : request channel (valid/ready)
//   dmem_rsp_valid/_rdata        : response channel (one-cycle pulse)
//   mem_wb_bus_out, mem_wb_valid : registered writeback payload
//   misaligned                   : registered one-cycle misalignment flag
// -----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
    import pipe_bus_pkg::*;
#(
    parameter int STORE_WAIT_RSP = 1
)(
    input  logic        clock,
    input  logic        reset,
    input  ex_mem_bus_t ex_mem_bus_in,
    input  logic        ex_mem_valid,
    output logic        mem_stall,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_req_addr,
    output logic        dmem_req_we,
    output logic [3:0]  dmem_req_wstrb,
    output logic [31:0] dmem_req_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_rdata,
    output mem_wb_bus_t mem_wb_bus_out,
    output logic        mem_wb_valid,
    output logic        misaligned
);

    mem_state_t  state_q, state_d;
    mem_wb_bus_t wb_q, wb_d;
    logic        wb_valid_q;
    logic        misaligned_q;

    logic [2:0]  funct3;
    logic [1:0]  off;
    logic        is_load, is_store, mem_op, misal;
    logic        req_valid, complete, stall;
    logic [31:0] load_val;

    assign funct3   = ex_mem_bus_in.instruction[14:12];
    assign off      = ex_mem_bus_in.alu_result[1:0];
    assign is_load  = ex_mem_valid && (ex_mem_bus_in.opcode == OPC_LOAD);
    assign is_store = ex_mem_valid && (ex_mem_bus_in.opcode == OPC_STORE);
    assign mem_op   = is_load || is_store;

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        misal = 1'b0;
        if (is_load && (funct3 == F3_LH || funct3 == F3_LHU))
            misal = off[0];
        else if (is_load && funct3 == F3_LW)
            misal = |off;
        else if (is_store && funct3 == F3_SH)
            misal = off[0];
        else if (is_store && funct3 == F3_SW)
            misal = |off;
    end
`else
    assign misal = 1'b0;
`endif

    // Next-state and request control
    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        complete  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (misal) begin
                    complete = 1'b1;            // dropped without a request
                end else if (mem_op) begin
                    req_valid = 1'b1;
                    if (dmem_req_ready) begin
                        if (is_store && STORE_WAIT_RSP == 0)
                            complete = 1'b1;
                        else
                            state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // A repeated ready here is ignored; only the response matters.
                if (dmem_rsp_valid) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
        endcase
    end

    assign stall = mem_op && !complete;

    // Request outputs are forced quiet while reset is held.
    assign mem_stall      = !reset && stall;
    assign dmem_req_valid = !reset && req_valid;
    assign dmem_req_we    = !reset && req_valid && is_store;
    assign dmem_req_wstrb = (!reset && req_valid && is_store) ? store_strb(funct3, off) : 4'b0000;
    assign dmem_req_addr  = {ex_mem_bus_in.alu_result[31:2], 2'b00};
    assign dmem_req_wdata = store_wdata(funct3, ex_mem_bus_in.b_val);

    mem_load_align u_align (
        .rdata_i  (dmem_rsp_rdata),
        .funct3_i (funct3),
        .off_i    (off),
        .value_o  (load_val)
    );

    always_comb begin
        wb_d.wb_value    = is_load ? load_val : ex_mem_bus_in.alu_result;
        wb_d.rd          = ex_mem_bus_in.rd;
        wb_d.opcode      = ex_mem_bus_in.opcode;
        wb_d.instruction = ex_mem_bus_in.instruction;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wb_q         <= '0;
            wb_valid_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            misaligned_q <= misal;
            if (stall) begin
                wb_valid_q <= 1'b0;             // bubble, payload held
            end else begin
                wb_valid_q <= ex_mem_valid && !misal;
                wb_q       <= wb_d;
            end
        end
    end

    assign mem_wb_bus_out = wb_q;
    assign mem_wb_valid   = wb_valid_q;
    assign misaligned     = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Directed vectors for mem_stage. Expected writeback results are queued when
// an op is issued; a negedge monitor pops and compares whenever mem_wb_valid
// is seen. A second instance covers stores completing on the handshake.
// -----------------------------------------------------------------------------
module tb_mem_stage;
    import mem_stage_pkg::*;
    import pipe_bus_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    always #5 clock = ~clock;

    ex_mem_bus_t ex_bus;
    logic        ex_valid, mem_stall;
    logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
    logic [31:0] dmem_req_addr, dmem_req_wdata, dmem_rsp_rdata;
    logic [3:0]  dmem_req_wstrb;
    logic        dmem_rsp_valid;
    mem_wb_bus_t wb_out;
    logic        wb_valid, misaligned;

    // second instance, STORE_WAIT_RSP = 0
    ex_mem_bus_t b_bus;
    logic        b_valid, b_stall, b_req_valid, b_ready, b_we, b_rsp_valid;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_wstrb;
    mem_wb_bus_t b_wb_out;
    logic        b_wb_valid, b_misaligned;

    mem_stage #(.STORE_WAIT_RSP(1)) dut (
        .clock(clock), .reset(reset),
        .ex_mem_bus_in(ex_bus), .ex_mem_valid(ex_valid), .mem_stall(mem_stall),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_addr(dmem_req_addr), .dmem_req_we(dmem_req_we),
        .dmem_req_wstrb(dmem_req_wstrb), .dmem_req_wdata(dmem_req_wdata),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
        .mem_wb_bus_out(wb_out), .mem_wb_valid(wb_valid), .misaligned(misaligned)
    );

    mem_stage #(.STORE_WAIT_RSP(0)) dut_sh (
        .clock(clock), .reset(reset),
        .ex_mem_bus_in(b_bus), .ex_mem_valid(b_valid), .mem_stall(b_stall),
        .dmem_req_valid(b_req_valid), .dmem_req_ready(b_ready),
        .dmem_req_addr(b_addr), .dmem_req_we(b_we),
        .dmem_req_wstrb(b_wstrb), .dmem_req_wdata(b_wdata),
        .dmem_rsp_valid(b_rsp_valid), .dmem_rsp_rdata(b_rdata),
        .mem_wb_bus_out(b_wb_out), .mem_wb_valid(b_wb_valid), .misaligned(b_misaligned)
    );

    typedef struct {
        logic [31:0] wb;
        logic [4:0]  rd;
        logic [6:0]  opc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   applied = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic ex_mem_bus_t mk(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [31:0] alu,
                                       input logic [31:0] bv);
        ex_mem_bus_t r;
        r.instruction = {17'd0, f3, rd, opc};
        r.alu_result  = alu;
        r.b_val       = bv;
        r.opcode      = opc;
        r.rd          = rd;
        return r;
    endfunction

    // Scoreboard monitor
    always @(negedge clock) begin
        if (!reset && wb_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected mem_wb_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("wb_value", wb_out.wb_value, mon_e.wb);
                chk("wb_rd", {27'd0, wb_out.rd}, {27'd0, mon_e.rd});
                chk("wb_opcode", {25'd0, wb_out.opcode}, {25'd0, mon_e.opc});
            end
        end
    end

    // Present one op at a negedge and play the memory side: ready low for
    // rdy_dly cycles, response rsp_dly cycles after the handshake.
    task automatic run_op(input string tag, input ex_mem_bus_t b, input int rdy_dly,
                          input int rsp_dly, input logic [31:0] rdata,
                          input logic [31:0] exp_wb, input int exp_stall, input int exp_reqs,
                          input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata);
        exp_t e;
        int   hs_c, stalls, reqs;
        bit   done;
        e.wb = exp_wb; e.rd = b.rd; e.opc = b.opcode;
        sb_q.push_back(e);
        hs_c = -1; stalls = 0; reqs = 0; done = 0;
        ex_bus = b; ex_valid = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            dmem_req_ready = (c >= rdy_dly);
            dmem_rsp_valid = (hs_c >= 0) && (c == hs_c + rsp_dly);
            dmem_rsp_rdata = dmem_rsp_valid ? rdata : 32'hDEADBEEF;
            #1;
            if (dmem_req_valid && dmem_req_ready) begin
                reqs++;
                if (hs_c < 0) begin
                    hs_c = c;
                    chk({tag, " addr"}, dmem_req_addr, exp_addr);
                    chk({tag, " we"}, {31'd0, dmem_req_we}, {31'd0, b.opcode == OPC_STORE});
                    chk({tag, " wstrb"}, {28'd0, dmem_req_wstrb}, {28'd0, exp_strb});
                    if (b.opcode == OPC_STORE)
                        chk({tag, " wdata"}, dmem_req_wdata, exp_wdata);
                end
            end
            if (mem_stall) stalls++;
            else           done = 1;
            @(negedge clock);
        end
        ex_valid = 1'b0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
        if (!done) chk({tag, " completion timeout"}, 32'd0, 32'd1);
        chk({tag, " stall cycles"}, stalls, exp_stall);
        chk({tag, " requests"}, reqs, exp_reqs);
    endtask

    initial begin
        reset = 1'b1;
        ex_bus = '0; ex_valid = 1'b0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0;
        b_bus = '0; b_valid = 1'b0; b_ready = 1'b0; b_rsp_valid = 1'b0; b_rdata = '0;

        // Reset state, with a load presented to show request outputs are gated
        repeat (2) @(negedge clock);
        ex_bus = mk(OPC_LOAD, F3_LW, 5'd3, 32'h40, 32'd0); ex_valid = 1'b1; dmem_req_ready = 1'b1;
        #1;
        chk("reset mem_stall", {31'd0, mem_stall}, 32'd0);
        chk("reset req_valid", {31'd0, dmem_req_valid}, 32'd0);
        chk("reset req_we", {31'd0, dmem_req_we}, 32'd0);
        chk("reset wstrb", {28'd0, dmem_req_wstrb}, 32'd0);
        chk("reset mem_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("reset wb_value", wb_out.wb_value, 32'd0);
        chk("reset misaligned", {31'd0, misaligned}, 32'd0);
        ex_valid = 1'b0; dmem_req_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        run_op("ADD", mk(7'b0110011, 3'b000, 5'd5, 32'h00001234, 32'd0), 0, 1, 32'd0,
               32'h00001234, 0, 0, 32'd0, 4'd0, 32'd0);
        run_op("LB", mk(OPC_LOAD, F3_LB, 5'd6, 32'h00000103, 32'd0), 0, 1, 32'h80FF0000,
               32'hFFFFFF80, 1, 1, 32'h00000100, 4'd0, 32'd0);
        run_op("LBU", mk(OPC_LOAD, F3_LBU, 5'd7, 32'h00000103, 32'd0), 0, 1, 32'h80FF0000,
               32'h00000080, 1, 1, 32'h00000100, 4'd0, 32'd0);
        run_op("LH", mk(OPC_LOAD, F3_LH, 5'd8, 32'h00000102, 32'd0), 0, 1, 32'h80FF0000,
               32'hFFFF80FF, 1, 1, 32'h00000100, 4'd0, 32'd0);
        run_op("LHU", mk(OPC_LOAD, F3_LHU, 5'd9, 32'h00000100, 32'd0), 0, 1, 32'h12348765,
               32'h00008765, 1, 1, 32'h00000100, 4'd0, 32'd0);
        run_op("LB1", mk(OPC_LOAD, F3_LB, 5'd10, 32'h00000101, 32'd0), 0, 1, 32'h00007F00,
               32'h0000007F, 1, 1, 32'h00000100, 4'd0, 32'd0);
        run_op("LW slow", mk(OPC_LOAD, F3_LW, 5'd11, 32'h00000200, 32'd0), 3, 2, 32'hCAFEF00D,
               32'hCAFEF00D, 5, 1, 32'h00000200, 4'd0, 32'd0);
        run_op("L f3=011", mk(OPC_LOAD, 3'b011, 5'd12, 32'h00000204, 32'd0), 0, 1, 32'h13579BDF,
               32'h13579BDF, 1, 1, 32'h00000204, 4'd0, 32'd0);
        run_op("SB", mk(OPC_STORE, F3_SB, 5'd13, 32'h00000201, 32'h000000A5), 2, 1, 32'd0,
               32'h00000201, 3, 1, 32'h00000200, 4'b0010, 32'hA5A5A5A5);
        run_op("SH", mk(OPC_STORE, F3_SH, 5'd14, 32'h00000102, 32'hABCD1234), 0, 1, 32'd0,
               32'h00000102, 1, 1, 32'h00000100, 4'b1100, 32'h12341234);
        run_op("SW", mk(OPC_STORE, F3_SW, 5'd15, 32'h00000300, 32'h11223344), 0, 1, 32'd0,
               32'h00000300, 1, 1, 32'h00000300, 4'b1111, 32'h11223344);
        run_op("ADD b2b", mk(7'b0110011, 3'b000, 5'd16, 32'h0000BEEF, 32'd0), 0, 1, 32'd0,
               32'h0000BEEF, 0, 0, 32'd0, 4'd0, 32'd0);

        // Reset while waiting for a response; the late pulse must be ignored
        ex_bus = mk(OPC_LOAD, F3_LW, 5'd17, 32'h00000400, 32'd0); ex_valid = 1'b1; dmem_req_ready = 1'b1;
        @(negedge clock);
        #1;
        chk("WAIT stall", {31'd0, mem_stall}, 32'd1);
        chk("WAIT no new request", {31'd0, dmem_req_valid}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst-in-WAIT mem_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst-in-WAIT mem_wb_valid", {31'd0, wb_valid}, 32'd0);
        @(negedge clock);
        ex_valid = 1'b0; dmem_req_ready = 1'b0; reset = 1'b0;
        @(negedge clock);
        dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h55555555;
        @(negedge clock);
        dmem_rsp_valid = 1'b0;
        chk("late rsp ignored", {31'd0, wb_valid}, 32'd0);
        run_op("LW after rst", mk(OPC_LOAD, F3_LW, 5'd18, 32'h00000404, 32'd0), 0, 1, 32'h0BADF00D,
               32'h0BADF00D, 1, 1, 32'h00000404, 4'd0, 32'd0);

        // Store completing on the handshake (STORE_WAIT_RSP = 0)
        b_bus = mk(OPC_STORE, F3_SH, 5'd4, 32'h00000102, 32'hABCD1234); b_valid = 1'b1; b_ready = 1'b0;
        #1;
        chk("SH0 stall while not ready", {31'd0, b_stall}, 32'd1);
        @(negedge clock);
        chk("SH0 bubble", {31'd0, b_wb_valid}, 32'd0);
        b_ready = 1'b1;
        #1;
        chk("SH0 no stall on handshake", {31'd0, b_stall}, 32'd0);
        chk("SH0 req_valid", {31'd0, b_req_valid}, 32'd1);
        chk("SH0 we", {31'd0, b_we}, 32'd1);
        chk("SH0 wstrb", {28'd0, b_wstrb}, 32'h0000000C);
        chk("SH0 wdata", b_wdata, 32'h12341234);
        chk("SH0 addr", b_addr, 32'h00000100);
        @(negedge clock);
        b_valid = 1'b0; b_ready = 1'b0;
        chk("SH0 mem_wb_valid", {31'd0, b_wb_valid}, 32'd1);
        chk("SH0 wb_value", b_wb_out.wb_value, 32'h00000102);
        #1;
        chk("SH0 idle after", {31'd0, b_req_valid}, 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
        ex_bus = mk(OPC_LOAD, F3_LW, 5'd19, 32'h00000102, 32'd0); ex_valid = 1'b1; dmem_req_ready = 1'b1;
        #1;
        chk("misal no request", {31'd0, dmem_req_valid}, 32'd0);
        chk("misal no stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clock);
        ex_valid = 1'b0; dmem_req_ready = 1'b0;
        chk("misal flag", {31'd0, misaligned}, 32'd1);
        chk("misal mem_wb_valid", {31'd0, wb_valid}, 32'd0);
        @(negedge clock);
        chk("misal flag clears", {31'd0, misaligned}, 32'd0);
`else
        run_op("LW off2", mk(OPC_LOAD, F3_LW, 5'd19, 32'h00000102, 32'd0), 0, 1, 32'h89ABCDEF,
               32'h89ABCDEF, 1, 1, 32'h00000100, 4'd0, 32'd0);
        chk("misaligned tied low", {31'd0, misaligned}, 32'd0);
`endif

        repeat (3) @(negedge clock);
        chk("scoreboard drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
